sw_debounce2: RTL and testbench

SW_DEBOUNCE2 -- requirements
Module: sw_debounce2

---
 rtl/sw_debounce_pkg.sv | 20 ++
 rtl/debounce_ch.sv | 117 +++++++++++
 rtl/sw_debounce2.sv | 40 ++++
 tb/tb_sw_debounce2.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/sw_debounce_pkg.sv
// rtl/sw_debounce_pkg.sv - shared state encoding and defaults for the switch debouncer
package sw_debounce_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'b00,
        PEND_HI   = 2'b01,
        STABLE_HI = 2'b10,
        PEND_LO   = 2'b11
    } db_state_e;

    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 4;

    // Counter must hold values up to the debounce length itself.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        int unsigned w;
        w = $clog2(cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/debounce_ch.sv
// rtl/debounce_ch.sv - one channel: two-flop synchroniser, debounce FSM and counter
module debounce_ch
    import sw_debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned    CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES);

    logic          meta_q;
    logic          sync_q;
    db_state_e     state_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          level_q;
    logic          rise_q;
    logic          fall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= sw_i;
            sync_q <= meta_q;
        end
    end

    assign cnt_d = cnt_q + CNT_ONE;

    // Pulses default low every cycle so each acceptance yields exactly one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= STABLE_LO;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            case (state_q)
                STABLE_LO: begin
                    if (sync_q) begin
                        if (CNT_ONE == CNT_LAST) begin
                            state_q <= STABLE_HI;
                            level_q <= 1'b1;
                            rise_q  <= 1'b1;
                            cnt_q   <= '0;
                        end else begin
                            state_q <= PEND_HI;
                            cnt_q   <= CNT_ONE;
                        end
                    end
                end
                PEND_HI: begin
                    if (!sync_q) begin
                        state_q <= STABLE_LO;
                        cnt_q   <= '0;
                    end else if (cnt_d == CNT_LAST) begin
                        state_q <= STABLE_HI;
                        level_q <= 1'b1;
                        rise_q  <= 1'b1;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                STABLE_HI: begin
                    if (!sync_q) begin
                        if (CNT_ONE == CNT_LAST) begin
                            state_q <= STABLE_LO;
                            level_q <= 1'b0;
                            fall_q  <= 1'b1;
                            cnt_q   <= '0;
                        end else begin
                            state_q <= PEND_LO;
                            cnt_q   <= CNT_ONE;
                        end
                    end
                end
                PEND_LO: begin
                    if (sync_q) begin
                        state_q <= STABLE_HI;
                        cnt_q   <= '0;
                    end else if (cnt_d == CNT_LAST) begin
                        state_q <= STABLE_LO;
                        level_q <= 1'b0;
                        fall_q  <= 1'b1;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: begin
                    state_q <= STABLE_LO;
                    cnt_q   <= '0;
                    level_q <= 1'b0;
                end
            endcase
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/sw_debounce2.sv
// rtl/sw_debounce2.sv - two debounced switch channels feeding a 2-input AND
module sw_debounce2
    import sw_debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw0_i,
    input  logic sw1_i,
    output logic sw0_o,
    output logic sw1_o,
    output logic sw0_rise,
    output logic sw1_rise,
    output logic sw0_fall,
    output logic sw1_fall,
    output logic and_o
);

    debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ch0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .sw_i    (sw0_i),
        .level_o (sw0_o),
        .rise_o  (sw0_rise),
        .fall_o  (sw0_fall)
    );

    debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ch1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .sw_i    (sw1_i),
        .level_o (sw1_o),
        .rise_o  (sw1_rise),
        .fall_o  (sw1_fall)
    );

    assign and_o = sw0_o & sw1_o;

endmodule

// File: tb/tb_sw_debounce2.sv
// tb/tb_sw_debounce2.sv - self-checking bench for sw_debounce2 (lengths 4 and 1)
module tb_sw_debounce2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic a_sw0 = 1'b0, a_sw1 = 1'b0, b_sw0 = 1'b0, b_sw1 = 1'b0;
    logic a_o0, a_o1, a_r0, a_r1, a_f0, a_f1, a_and;
    logic b_o0, b_o1, b_r0, b_r1, b_f0, b_f1, b_and;

    int tests = 0;
    int fails = 0;
    bit done = 1'b0;

    always #5 clk = ~clk;

    sw_debounce2 #(.DEBOUNCE_CYCLES(4)) u_a (
        .clk(clk), .rst_n(rst_n), .sw0_i(a_sw0), .sw1_i(a_sw1),
        .sw0_o(a_o0), .sw1_o(a_o1), .sw0_rise(a_r0), .sw1_rise(a_r1),
        .sw0_fall(a_f0), .sw1_fall(a_f1), .and_o(a_and)
    );

    sw_debounce2 #(.DEBOUNCE_CYCLES(1)) u_b (
        .clk(clk), .rst_n(rst_n), .sw0_i(b_sw0), .sw1_i(b_sw1),
        .sw0_o(b_o0), .sw1_o(b_o1), .sw0_rise(b_r0), .sw1_rise(b_r1),
        .sw0_fall(b_f0), .sw1_fall(b_f1), .and_o(b_and)
    );

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: raw reaches the decision point two edges late; the accepted
    // level flips once D consecutive delayed samples disagree with it.
    int dcyc[2] = '{4, 1};
    bit m_p1[2][2], m_p2[2][2], m_lvl[2][2], m_r[2][2], m_f[2][2];
    int m_st[2][2];

    function automatic bit raw_in(input int d, input int ch);
        if (d == 0) return (ch == 0) ? a_sw0 : a_sw1;
        return (ch == 0) ? b_sw0 : b_sw1;
    endfunction

    function automatic int dut_out(input int d, input int ch, input int k);
        logic [2:0] v;
        if (d == 0) v = (ch == 0) ? {a_o0, a_r0, a_f0} : {a_o1, a_r1, a_f1};
        else        v = (ch == 0) ? {b_o0, b_r0, b_f0} : {b_o1, b_r1, b_f1};
        return int'(v[2-k]);
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            for (int d = 0; d < 2; d++) begin
                for (int ch = 0; ch < 2; ch++) begin
                    if (!rst_n) begin
                        m_p1[d][ch] = 0; m_p2[d][ch] = 0; m_lvl[d][ch] = 0;
                        m_r[d][ch] = 0; m_f[d][ch] = 0; m_st[d][ch] = 0;
                    end else begin
                        m_r[d][ch] = 0;
                        m_f[d][ch] = 0;
                        if (m_p2[d][ch] != m_lvl[d][ch]) begin
                            m_st[d][ch]++;
                            if (m_st[d][ch] >= dcyc[d]) begin
                                m_lvl[d][ch] = m_p2[d][ch];
                                if (m_p2[d][ch]) m_r[d][ch] = 1; else m_f[d][ch] = 1;
                                m_st[d][ch] = 0;
                            end
                        end else begin
                            m_st[d][ch] = 0;
                        end
                        m_p2[d][ch] = m_p1[d][ch];
                        m_p1[d][ch] = raw_in(d, ch);
                    end
                end
            end
        end
    end

    initial begin
        while (!done) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                for (int ch = 0; ch < 2; ch++) begin
                    chk($sformatf("lvl d%0d ch%0d", d, ch), dut_out(d, ch, 0), int'(m_lvl[d][ch]));
                    chk($sformatf("rise d%0d ch%0d", d, ch), dut_out(d, ch, 1), int'(m_r[d][ch]));
                    chk($sformatf("fall d%0d ch%0d", d, ch), dut_out(d, ch, 2), int'(m_f[d][ch]));
                    chk($sformatf("excl d%0d ch%0d", d, ch), dut_out(d, ch, 1) & dut_out(d, ch, 2), 0);
                end
            end
            chk("and_a", int'(a_and), int'(m_lvl[0][0] & m_lvl[0][1]));
            chk("and_b", int'(b_and), int'(m_lvl[1][0] & m_lvl[1][1]));
        end
    end

    initial begin
        bit seq[9] = '{1, 0, 1, 1, 0, 1, 1, 1, 1};
        int n;
        int at;

        repeat (3) @(negedge clk);
        chk("reset_o0", int'(a_o0), 0);
        chk("reset_r0", int'(a_r0), 0);
        chk("reset_and", int'(a_and), 0);
        chk("reset_b_o0", int'(b_o0), 0);
        rst_n = 1'b1;

        // Clean rise on sw0: accepted on the sixth edge
        a_sw0 = 1'b1;
        repeat (5) @(negedge clk);
        chk("A_pre_lvl", int'(a_o0), 0);
        @(negedge clk);
        chk("A_lvl", int'(a_o0), 1);
        chk("A_rise", int'(a_r0), 1);
        chk("A_and", int'(a_and), 0);
        chk("A_model_lvl", int'(m_lvl[0][0]), 1);
        @(negedge clk);
        chk("A_rise_once", int'(a_r0), 0);

        // Three-cycle glitch on sw1 is rejected
        a_sw1 = 1'b1;
        repeat (3) @(negedge clk);
        a_sw1 = 1'b0;
        n = 0;
        repeat (10) begin
            @(negedge clk);
            n += int'(a_r1) + int'(a_f1);
        end
        chk("B_pulses", n, 0);
        chk("B_lvl", int'(a_o1), 0);

        // Bounce sequence on sw0 gives one rise, 4 edges after last sync rise
        a_sw0 = 1'b0;
        repeat (8) @(negedge clk);
        chk("C_pre_lvl", int'(a_o0), 0);
        n = 0;
        at = -1;
        for (int i = 0; i < 16; i++) begin
            a_sw0 = (i < 9) ? seq[i] : 1'b1;
            @(negedge clk);
            if (a_r0) begin
                n++;
                at = i + 1;
            end
        end
        chk("C_rise_count", n, 1);
        chk("C_rise_edge", at, 11);

        // Simultaneous rises, then sw0 fall drops and_o
        a_sw0 = 1'b0;
        repeat (8) @(negedge clk);
        a_sw0 = 1'b1;
        a_sw1 = 1'b1;
        repeat (5) @(negedge clk);
        chk("D_pre_o0", int'(a_o0), 0);
        chk("D_pre_o1", int'(a_o1), 0);
        @(negedge clk);
        chk("D_rise0", int'(a_r0), 1);
        chk("D_rise1", int'(a_r1), 1);
        chk("D_and_hi", int'(a_and), 1);
        repeat (2) @(negedge clk);
        a_sw0 = 1'b0;
        repeat (5) @(negedge clk);
        chk("D_and_hold", int'(a_and), 1);
        @(negedge clk);
        chk("D_fall0", int'(a_f0), 1);
        chk("D_and_lo", int'(a_and), 0);
        chk("D_o1", int'(a_o1), 1);

        // Reset mid-pending: immediate clear, then full latency after release
        a_sw0 = 1'b1;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("E_async_o1", int'(a_o1), 0);
        chk("E_async_and", int'(a_and), 0);
        chk("E_async_r0", int'(a_r0), 0);
        chk("E_async_f1", int'(a_f1), 0);
        repeat (3) @(negedge clk);
        chk("E_hold_o0", int'(a_o0), 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("E_pre_o0", int'(a_o0), 0);
        chk("E_pre_o1", int'(a_o1), 0);
        @(negedge clk);
        chk("E_rise0", int'(a_r0), 1);
        chk("E_rise1", int'(a_r1), 1);
        chk("E_and", int'(a_and), 1);

        // Length 1: single-cycle raw high passes straight through
        b_sw0 = 1'b1;
        @(negedge clk);
        b_sw0 = 1'b0;
        @(negedge clk);
        chk("F_pre", int'(b_o0), 0);
        @(negedge clk);
        chk("F_lvl_hi", int'(b_o0), 1);
        chk("F_rise", int'(b_r0), 1);
        @(negedge clk);
        chk("F_lvl_lo", int'(b_o0), 0);
        chk("F_fall", int'(b_f0), 1);
        chk("F_no_rise", int'(b_r0), 0);

        // Bouncy traffic on all inputs, checked cycle by cycle against the model
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 5) == 0) a_sw0 = ~a_sw0;
            if ($urandom_range(0, 5) == 0) a_sw1 = ~a_sw1;
            if ($urandom_range(0, 3) == 0) b_sw0 = ~b_sw0;
            if ($urandom_range(0, 3) == 0) b_sw1 = ~b_sw1;
            if (i == 200) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        done = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
